// File: rtl/sensor_capture_if.sv
// sensor_capture_if
//   Bundles the sensor-side inputs and capture-side outputs of the
//   sensor capture sequencer.
//   master : the sequencer (sensor_capture_ctrl) - samples vsync/init/request,
//            drives capture gate, init request, state and counters.
//   slave  : the surrounding environment (sensor config engine, writer, control).
//   Signals:
//     cmos_vsync      raw sensor vsync, high during frame, asynchronous
//     cmos_init_done  sensor configuration engine done level
//     capture_req     level request to capture frames
//     capture_en      frame gate to the writer, frame-boundary aligned
//     cmos_init_req   one-cycle sensor re-configuration request
//     ctrl_state      IDLE=0 SKIP=1 RUN=2 REINIT=3 FAULT=4
//     sensor_fault    sticky fault flag
//     retry_cnt       re-init attempts since last entry to RUN
//     frame_total     captured-frame counter (wraps)
interface sensor_capture_if;
   logic        cmos_vsync;
   logic        cmos_init_done;
   logic        capture_req;
   logic        capture_en;
   logic        cmos_init_req;
   logic [2:0]  ctrl_state;
   logic        sensor_fault;
   logic [3:0]  retry_cnt;
   logic [15:0] frame_total;

   modport master (
      input  cmos_vsync, cmos_init_done, capture_req,
      output capture_en, cmos_init_req, ctrl_state, sensor_fault,
             retry_cnt, frame_total
   );

   modport slave (
      output cmos_vsync, cmos_init_done, capture_req,
      input  capture_en, cmos_init_req, ctrl_state, sensor_fault,
             retry_cnt, frame_total
   );
endinterface

// File: rtl/sensor_capture_ctrl.sv
// sensor_capture_ctrl
//   Sequencer between the sensor configuration engine and the frame capture
//   path. After configuration it drops SKIP_FRAMES settling frames, then gates
//   capture on frame boundaries (falling vsync). With the watchdog build it
//   also detects vsync stalls, re-initialises the sensor up to MAX_RETRY times
//   and then latches a fault.
//
//   Build option: define SENSOR_CAPTURE_WDT_EN to include the watchdog,
//   REINIT, retry and FAULT logic. Without it, timeout never fires and
//   cmos_init_req / sensor_fault / retry_cnt are tied to 0; the state
//   encoding is the same in both builds.
//
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  sensor_capture_if.master (see interface header for signal list)
module sensor_capture_ctrl #(
   parameter int unsigned CLOCK_MAIN  = 100_000_000,
   parameter int unsigned SKIP_FRAMES = 10,
   parameter int unsigned TIMEOUT_MS  = 100,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic             clk,
   input  logic             rst,
   sensor_capture_if.master bus
);

   // Illegal parameter combinations stop elaboration.
   if (SKIP_FRAMES < 1 || SKIP_FRAMES > 255 || MAX_RETRY < 1 || MAX_RETRY > 15 ||
       TIMEOUT_MS < 1 || CLOCK_MAIN < 1000) begin : g_bad_param
      $error("sensor_capture_ctrl: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SKIP   = 3'd1,
      ST_RUN    = 3'd2,
      ST_REINIT = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   localparam logic [7:0] SKIP_LAST = 8'(SKIP_FRAMES - 1);

   state_t      state;
   logic        vs_meta;
   logic [1:0]  vs_r;
   logic        vsync_end;
   logic        cap_en;
   logic [7:0]  skip_cnt;
   logic [15:0] frame_cnt;
   logic        timeout;

   // vs_meta is the metastability stage; vs_r[0] is the synchronised level
   // and vs_r[1] its previous value, so vs_r[1] & ~vs_r[0] is a clean
   // falling-edge (frame boundary) strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_meta <= 1'b0;
         vs_r    <= 2'b00;
      end else begin
         vs_meta <= bus.cmos_vsync;
         vs_r    <= {vs_r[0], vs_meta};
      end
   end

   assign vsync_end = vs_r[1] & ~vs_r[0];

`ifdef SENSOR_CAPTURE_WDT_EN
   typedef enum logic [1:0] {
      RP_ENTRY   = 2'd0,
      RP_WAIT_LO = 2'd1,
      RP_WAIT_HI = 2'd2
   } rphase_t;

   localparam logic [31:0] WDT_LIMIT = 32'(TIMEOUT_MS * (CLOCK_MAIN / 1000) - 1);
   localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

   rphase_t     rphase;
   logic [31:0] wdt;
   logic        init_req;
   logic        fault;
   logic [3:0]  retry;

   assign timeout = (wdt == WDT_LIMIT);

   // Every way out of SKIP/RUN coincides with vsync_end, timeout or init_done
   // low, and the count is held at 0 elsewhere, so these terms cover the
   // clear-on-state-change rule without decoding the next state.
   always_ff @(posedge clk) begin
      if (rst)
         wdt <= '0;
      else if (vsync_end || timeout || !bus.cmos_init_done ||
               !(state == ST_SKIP || state == ST_RUN))
         wdt <= '0;
      else
         wdt <= wdt + 32'd1;
   end

   assign bus.cmos_init_req = init_req;
   assign bus.sensor_fault  = fault;
   assign bus.retry_cnt     = retry;
`else
   assign timeout           = 1'b0;
   assign bus.cmos_init_req = 1'b0;
   assign bus.sensor_fault  = 1'b0;
   assign bus.retry_cnt     = 4'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cap_en    <= 1'b0;
         skip_cnt  <= '0;
         frame_cnt <= '0;
`ifdef SENSOR_CAPTURE_WDT_EN
         rphase    <= RP_ENTRY;
         init_req  <= 1'b0;
         fault     <= 1'b0;
         retry     <= '0;
`endif
      end else begin
`ifdef SENSOR_CAPTURE_WDT_EN
         init_req <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               cap_en <= 1'b0;
               if (bus.cmos_init_done) begin
                  state    <= ST_SKIP;
                  skip_cnt <= '0;
               end
            end

            ST_SKIP: begin
               cap_en <= 1'b0;
               // init_done loss takes priority over a coincident boundary.
               if (!bus.cmos_init_done) begin
                  state <= ST_IDLE;
               end else if (vsync_end) begin
                  skip_cnt <= skip_cnt + 8'd1;
                  if (skip_cnt == SKIP_LAST) begin
                     state <= ST_RUN;
`ifdef SENSOR_CAPTURE_WDT_EN
                     retry <= '0;
`endif
                  end
`ifdef SENSOR_CAPTURE_WDT_EN
               end else if (timeout) begin
                  state  <= ST_REINIT;
                  rphase <= RP_ENTRY;
`endif
               end
            end

            ST_RUN: begin
               if (!bus.cmos_init_done) begin
                  cap_en <= 1'b0;
                  state  <= ST_IDLE;
               end else if (vsync_end) begin
                  // A boundary with the gate already open closes a captured
                  // frame; the gate then follows the request for the next one.
                  if (cap_en)
                     frame_cnt <= frame_cnt + 16'd1;
                  cap_en <= bus.capture_req;
`ifdef SENSOR_CAPTURE_WDT_EN
               end else if (timeout) begin
                  cap_en <= 1'b0;
                  state  <= ST_REINIT;
                  rphase <= RP_ENTRY;
`endif
               end
            end

`ifdef SENSOR_CAPTURE_WDT_EN
            ST_REINIT: begin
               cap_en <= 1'b0;
               case (rphase)
                  RP_ENTRY: begin
                     if (retry == RETRY_LIM) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                     end else begin
                        init_req <= 1'b1;
                        retry    <= retry + 4'd1;
                        rphase   <= RP_WAIT_LO;
                     end
                  end
                  // The engine must visibly restart: see done low, then high.
                  RP_WAIT_LO: begin
                     if (!bus.cmos_init_done)
                        rphase <= RP_WAIT_HI;
                  end
                  default: begin
                     if (bus.cmos_init_done) begin
                        state    <= ST_SKIP;
                        skip_cnt <= '0;
                     end
                  end
               endcase
            end

            ST_FAULT: begin
               cap_en <= 1'b0;
               fault  <= 1'b1;
            end
`endif

            default: begin
               cap_en <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.capture_en  = cap_en;
   assign bus.ctrl_state  = state;
   assign bus.frame_total = frame_cnt;

endmodule
